// File: rtl/occupancy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : occupancy_pkg
// Description : Shared types and constants for the occupancy controller.
//               Defines the gate state encoding, the idle code of the
//               entry/exit FSM and the default parameter values.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package occupancy_pkg;

    typedef enum logic [1:0] {
        G_CLOSED  = 2'd0,
        G_OPEN    = 2'd1,
        G_CLOSING = 2'd2
    } gate_state_t;

    localparam logic [2:0] FSM_IDLE = 3'b000;

    localparam int DEF_CAPACITY     = 8;
    localparam int DEF_GATE_CYCLES  = 16;
    localparam int DEF_CLOSE_CYCLES = 4;
    localparam int DEF_TIMEOUT      = 32;

endpackage : occupancy_pkg
`default_nettype wire

// File: rtl/occupancy_controller_timer.sv
`default_nettype none
// ============================================================================
// Module      : oc_timer
// Description : Loadable down-counter. load has priority over en; the count
//               stops at zero. zero is decoded from the count register.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous reset, active low
//               load  - load value into the counter
//               value - load value
//               en    - decrement by one (when not at zero)
//               zero  - counter is zero
// Revision    : 1.0 - initial release
// ============================================================================
module oc_timer #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= value;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule : oc_timer
`default_nettype wire

// File: rtl/occupancy_controller.sv
`default_nettype none
// ============================================================================
// Module      : occupancy_controller
// Description : Supervisory controller for the two-sensor entry/exit FSM.
//               Tracks occupancy against CAPACITY with sticky overflow /
//               underflow flags, sequences the entry gate (open-hold then
//               closing phase) and runs a watchdog that pulses fsm_clear
//               when the FSM stays non-idle too long.
// Ports       : clk, reset (async, active low)
//               entered/exited  - one-cycle pulses from the FSM
//               fsm_state       - FSM current state, 3'b000 = idle
//               req_entry       - vehicle waiting at the entry sensor
//               clear_err       - synchronous clear of the error flags
//               fsm_clear       - one-cycle pulse forcing the FSM idle
//               count/full/empty- occupancy and its decodes
//               gate_open/gate_busy - gate drive / closing phase
//               overflow_err/underflow_err - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module occupancy_controller
    import occupancy_pkg::*;
#(
    parameter int CAPACITY     = DEF_CAPACITY,
    parameter int GATE_CYCLES  = DEF_GATE_CYCLES,
    parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES,
    parameter int TIMEOUT      = DEF_TIMEOUT,
    localparam int CW          = $clog2(CAPACITY + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          entered,
    input  logic          exited,
    input  logic [2:0]    fsm_state,
    input  logic          req_entry,
    input  logic          clear_err,
    output logic          fsm_clear,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          gate_open,
    output logic          gate_busy,
    output logic          overflow_err,
    output logic          underflow_err
);

    localparam int GMAX = (GATE_CYCLES > CLOSE_CYCLES) ? GATE_CYCLES : CLOSE_CYCLES;
    localparam int GW   = $clog2(GMAX + 1);
    localparam int WW   = $clog2(TIMEOUT + 1);

    // ------------------------------------------------------------------
    // Occupancy counter and sticky errors
    // ------------------------------------------------------------------
    logic inc_req;
    logic dec_req;
    logic ovf_event;
    logic udf_event;

    assign inc_req   = entered && !exited;
    assign dec_req   = exited && !entered;
    assign full      = (count == CW'(CAPACITY));
    assign empty     = (count == '0);
    assign ovf_event = inc_req && full;
    assign udf_event = dec_req && empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (inc_req && !full) begin
                count <= count + CW'(1);
            end else if (dec_req && !empty) begin
                count <= count - CW'(1);
            end
            // A new error event outranks a simultaneous clear.
            if (ovf_event) begin
                overflow_err <= 1'b1;
            end else if (clear_err) begin
                overflow_err <= 1'b0;
            end
            if (udf_event) begin
                underflow_err <= 1'b1;
            end else if (clear_err) begin
                underflow_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Gate FSM
    // ------------------------------------------------------------------
    gate_state_t   gate_state;
    gate_state_t   gate_next;
    logic          gt_load;
    logic [GW-1:0] gt_value;
    logic          gt_en;
    logic          gt_zero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gate_state <= G_CLOSED;
        end else begin
            gate_state <= gate_next;
        end
    end

    always_comb begin
        gate_next = gate_state;
        gt_load   = 1'b0;
        gt_value  = '0;
        gt_en     = 1'b0;
        case (gate_state)
            G_CLOSED: begin
                if (req_entry && !full) begin
                    gate_next = G_OPEN;
                    gt_load   = 1'b1;
                    gt_value  = GW'(GATE_CYCLES - 1);
                end
            end
            G_OPEN: begin
                // Entry and expiry together still make a single move to closing.
                if (entered || gt_zero) begin
                    gate_next = G_CLOSING;
                    gt_load   = 1'b1;
                    gt_value  = GW'(CLOSE_CYCLES - 1);
                end else begin
                    gt_en = 1'b1;
                end
            end
            G_CLOSING: begin
                if (gt_zero) begin
                    gate_next = G_CLOSED;
                end else begin
                    gt_en = 1'b1;
                end
            end
            default: begin
                gate_next = G_CLOSED;
            end
        endcase
    end

    always_comb begin
        gate_open = (gate_state == G_OPEN);
        gate_busy = (gate_state == G_CLOSING);
    end

    oc_timer #(
        .W       (GW),
        .RST_VAL ('0)
    ) u_gate_timer (
        .clk   (clk),
        .reset (reset),
        .load  (gt_load),
        .value (gt_value),
        .en    (gt_en),
        .zero  (gt_zero)
    );

    // ------------------------------------------------------------------
    // Watchdog
    // The timer holds the cycles remaining before a fire, so "elapsed = 0"
    // is represented by TIMEOUT-1; it reloads whenever the FSM is idle or
    // right after a fire, which re-arms it for a still-stuck FSM.
    // ------------------------------------------------------------------
    logic fsm_busy;
    logic wd_zero;
    logic wd_fire;

    assign fsm_busy = (fsm_state != FSM_IDLE);
    assign wd_fire  = fsm_busy && wd_zero;

    oc_timer #(
        .W       (WW),
        .RST_VAL (WW'(TIMEOUT - 1))
    ) u_wd_timer (
        .clk   (clk),
        .reset (reset),
        .load  (!fsm_busy || wd_fire),
        .value (WW'(TIMEOUT - 1)),
        .en    (fsm_busy),
        .zero  (wd_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_clear <= 1'b0;
        end else begin
            fsm_clear <= wd_fire;
        end
    end

endmodule : occupancy_controller
`default_nettype wire

// File: tb/tb_occupancy_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_occupancy_controller
// Description : Directed self-checking bench. Two controller instances share
//               the stimulus: dut_a (CAPACITY 8) and dut_b (CAPACITY 2), both
//               with GATE_CYCLES 4, CLOSE_CYCLES 2, TIMEOUT 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_occupancy_controller;

    logic       clk;
    logic       reset;
    logic       entered;
    logic       exited;
    logic [2:0] fsm_state;
    logic       req_entry;
    logic       clear_err;

    logic       fsm_clear_a, full_a, empty_a, gate_open_a, gate_busy_a, ovf_a, udf_a;
    logic [3:0] count_a;
    logic       fsm_clear_b, full_b, empty_b, gate_open_b, gate_busy_b, ovf_b, udf_b;
    logic [1:0] count_b;

    int checks;
    int errors;

    occupancy_controller #(
        .CAPACITY(8), .GATE_CYCLES(4), .CLOSE_CYCLES(2), .TIMEOUT(8)
    ) dut_a (
        .clk(clk), .reset(reset), .entered(entered), .exited(exited),
        .fsm_state(fsm_state), .req_entry(req_entry), .clear_err(clear_err),
        .fsm_clear(fsm_clear_a), .count(count_a), .full(full_a), .empty(empty_a),
        .gate_open(gate_open_a), .gate_busy(gate_busy_a),
        .overflow_err(ovf_a), .underflow_err(udf_a)
    );

    occupancy_controller #(
        .CAPACITY(2), .GATE_CYCLES(4), .CLOSE_CYCLES(2), .TIMEOUT(8)
    ) dut_b (
        .clk(clk), .reset(reset), .entered(entered), .exited(exited),
        .fsm_state(fsm_state), .req_entry(req_entry), .clear_err(clear_err),
        .fsm_clear(fsm_clear_b), .count(count_b), .full(full_b), .empty(empty_b),
        .gate_open(gate_open_b), .gate_busy(gate_busy_b),
        .overflow_err(ovf_b), .underflow_err(udf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        entered   = 1'b0;
        exited    = 1'b0;
        fsm_state = 3'b000;
        req_entry = 1'b0;
        clear_err = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic pulse_entry();
        entered = 1'b1;
        tick();
        entered = 1'b0;
    endtask

    task automatic pulse_exit();
        exited = 1'b1;
        tick();
        exited = 1'b0;
    endtask

    initial begin
        logic seen;
        checks = 0;
        errors = 0;
        reset  = 1'b0;

        // ---------------- Reset values ----------------
        do_reset();
        reset = 1'b0;
        tick();
        check("rst_count", 32'(count_a), 0);
        check("rst_empty", 32'(empty_a), 1);
        check("rst_full", 32'(full_a), 0);
        check("rst_gate_open", 32'(gate_open_a), 0);
        check("rst_gate_busy", 32'(gate_busy_a), 0);
        check("rst_fsm_clear", 32'(fsm_clear_a), 0);
        check("rst_errs", 32'({ovf_a, udf_a}), 0);

        // ---------------- 1: three entries ----------------
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            entered = 1'b1;
            #1;
            check("t1_count_before_edge", 32'(count_a), 32'(i - 1));
            tick();
            entered = 1'b0;
            check("t1_count_after_edge", 32'(count_a), 32'(i));
            tick();
        end
        check("t1_empty", 32'(empty_a), 0);
        check("t1_full", 32'(full_a), 0);

        // ---------------- 2: capacity 2 overflow / underflow ----------------
        do_reset();
        pulse_entry();
        pulse_entry();
        check("t2_no_ovf_at_fill", 32'(ovf_b), 0);
        pulse_entry();
        check("t2_count_held", 32'(count_b), 2);
        check("t2_full", 32'(full_b), 1);
        check("t2_ovf", 32'(ovf_b), 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("t2_ovf_cleared", 32'(ovf_b), 0);
        check("t2_count_after_clear", 32'(count_b), 2);
        clear_err = 1'b1;
        entered   = 1'b1;
        tick();
        clear_err = 1'b0;
        entered   = 1'b0;
        check("t2_set_beats_clear", 32'(ovf_b), 1);
        pulse_exit();
        pulse_exit();
        check("t2_empty", 32'(empty_b), 1);
        check("t2_no_udf_yet", 32'(udf_b), 0);
        pulse_exit();
        check("t2_udf", 32'(udf_b), 1);
        check("t2_count_zero", 32'(count_b), 0);

        // ---------------- 3: simultaneous entry/exit ----------------
        do_reset();
        pulse_entry();
        entered = 1'b1;
        exited  = 1'b1;
        tick();
        entered = 1'b0;
        exited  = 1'b0;
        check("t3_count", 32'(count_a), 1);
        check("t3_errs", 32'({ovf_a, udf_a}), 0);

        // ---------------- 4: gate timing ----------------
        do_reset();
        req_entry = 1'b1;
        #1;
        check("t4_open_not_yet", 32'(gate_open_a), 0);
        tick();
        check("t4_open_c1", 32'(gate_open_a), 1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("t4_open_hold", 32'({gate_open_a, gate_busy_a}), 2);
        end
        tick();
        check("t4_closing_c1", 32'({gate_open_a, gate_busy_a}), 1);
        tick();
        check("t4_closing_c2", 32'({gate_open_a, gate_busy_a}), 1);
        tick();
        check("t4_closed", 32'({gate_open_a, gate_busy_a}), 0);
        tick();
        check("t4_reopen", 32'(gate_open_a), 1);
        tick();
        check("t4_open_c2", 32'(gate_open_a), 1);
        entered = 1'b1;
        tick();
        entered = 1'b0;
        check("t4_entry_closes", 32'({gate_open_a, gate_busy_a}), 1);
        check("t4_entry_count", 32'(count_a), 1);
        req_entry = 1'b0;

        // ---------------- 5: full keeps gate closed ----------------
        do_reset();
        pulse_entry();
        pulse_entry();
        check("t5_full", 32'(full_b), 1);
        req_entry = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen = seen | gate_open_b | gate_busy_b;
        end
        check("t5_gate_closed", 32'(seen), 0);
        req_entry = 1'b0;

        // ---------------- 6: watchdog ----------------
        do_reset();
        pulse_entry();
        fsm_state = 3'b001;
        for (int i = 1; i <= 17; i++) begin
            tick();
            check($sformatf("t6_wd_cycle%0d", i), 32'(fsm_clear_a),
                  ((i == 8) || (i == 16)) ? 32'd1 : 32'd0);
        end
        check("t6_count_untouched", 32'(count_a), 1);
        fsm_state = 3'b000;
        tick();
        fsm_state = 3'b010;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | fsm_clear_a;
        end
        fsm_state = 3'b000;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen = seen | fsm_clear_a;
        end
        check("t6_no_pulse_short", 32'(seen), 0);

        // Asynchronous reset while open
        req_entry = 1'b1;
        tick();
        check("t6_open_before_rst", 32'(gate_open_a), 1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_gate", 32'({gate_open_a, gate_busy_a}), 0);
        check("t6_async_count", 32'(count_a), 0);
        req_entry = 1'b0;
        tick();
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_occupancy_controller
`default_nettype wire
